// File: rtl/xvec2_md_sequencer_if.sv
// Request/response bundle shared by the vector side and the scalar
// multiply/divide side of the sequencer. The same shape serves both: the
// vector instance is LANES*XPR_LEN wide, the scalar instance XPR_LEN wide.
interface xvec2_md_sequencer_if #(
    parameter int WIDTH         = 32,
    parameter int OP_WIDTH      = 2,
    parameter int OUT_SEL_WIDTH = 2
);
    logic                     req_valid;
    logic                     req_ready;
    logic [OP_WIDTH-1:0]      req_op;
    logic [OUT_SEL_WIDTH-1:0] req_out_sel;
    logic                     req_in_1_signed;
    logic                     req_in_2_signed;
    logic [WIDTH-1:0]         req_in_1;
    logic [WIDTH-1:0]         req_in_2;
    logic                     resp_valid;
    logic [WIDTH-1:0]         resp_result;

    // Requester side: issues operations, receives results.
    modport master (
        output req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
               req_in_1, req_in_2,
        input  req_ready, resp_valid, resp_result
    );

    // Responder side: accepts operations, produces results.
    modport slave (
        input  req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
               req_in_1, req_in_2,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/xvec2_md_sequencer.sv
// Runs one vector multiply/divide across a single shared scalar mul/div unit,
// one lane at a time (lane 0 first). Operands and control are latched on
// accept, each lane is issued as one scalar request, the scalar results are
// gathered into the vector result register and a one-cycle response pulse
// is produced once all lanes are back.
module xvec2_md_sequencer #(
    parameter int XPR_LEN          = 32,
    parameter int LANES            = 4,
    parameter int MD_OP_WIDTH      = 2,
    parameter int MD_OUT_SEL_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   kill,
    xvec2_md_sequencer_if.slave    vec,
    xvec2_md_sequencer_if.master   md
);

    localparam int VEC_W  = LANES * XPR_LEN;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t                      state_reg, state_next;
    logic [LANE_W-1:0]           lane_reg, lane_next, lane_inc;

    logic [MD_OP_WIDTH-1:0]      op_reg;
    logic [MD_OUT_SEL_WIDTH-1:0] out_sel_reg;
    logic                        in_1_signed_reg;
    logic                        in_2_signed_reg;
    logic [VEC_W-1:0]            in_1_reg;
    logic [VEC_W-1:0]            in_2_reg;
    logic [XPR_LEN-1:0]          md_in_1_reg;
    logic [XPR_LEN-1:0]          md_in_2_reg;

    logic [XPR_LEN-1:0]          in_1_lane [LANES];
    logic [XPR_LEN-1:0]          in_2_lane [LANES];
    logic [XPR_LEN-1:0]          res_lane_reg [LANES];
    logic [VEC_W-1:0]            result_vec;

    logic                        accept;
    logic                        lane_wr;
    logic                        lane_adv;
    logic                        req_ready_c;
    logic                        md_req_valid_c;
    logic                        resp_valid_c;

    assign lane_inc = lane_reg + LANE_W'(1);

    // Lane views of the latched operands.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign in_1_lane[gi] = in_1_reg[gi*XPR_LEN +: XPR_LEN];
            assign in_2_lane[gi] = in_2_reg[gi*XPR_LEN +: XPR_LEN];
        end
    endgenerate

    // State and lane counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            lane_reg  <= '0;
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
        end
    end

    // Next state, lane advance and the three combinational handshake outputs.
    always_comb begin
        state_next     = state_reg;
        lane_next      = lane_reg;
        accept         = 1'b0;
        lane_wr        = 1'b0;
        lane_adv       = 1'b0;
        req_ready_c    = 1'b0;
        md_req_valid_c = 1'b0;
        resp_valid_c   = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                req_ready_c = !kill && !reset;
                if (vec.req_valid && req_ready_c) begin
                    accept     = 1'b1;
                    lane_next  = '0;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                md_req_valid_c = !kill;
                if (kill) begin
                    state_next = S_IDLE;
                end else if (md.req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (md.resp_valid) begin
                    if (kill) begin
                        // Result belongs to a killed instruction: drop it.
                        state_next = S_IDLE;
                    end else begin
                        lane_wr = 1'b1;
                        if (lane_reg == LAST_LANE) begin
                            state_next = S_DONE;
                        end else begin
                            lane_adv   = 1'b1;
                            lane_next  = lane_inc;
                            state_next = S_ISSUE;
                        end
                    end
                end else if (kill) begin
                    // The scalar unit cannot abort; swallow its late result.
                    state_next = S_DRAIN;
                end
            end
            S_DONE: begin
                resp_valid_c = !kill;
                state_next   = S_IDLE;
            end
            S_DRAIN: begin
                if (md.resp_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand/control latch plus the registered per-lane scalar operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg          <= '0;
            out_sel_reg     <= '0;
            in_1_signed_reg <= 1'b0;
            in_2_signed_reg <= 1'b0;
            in_1_reg        <= '0;
            in_2_reg        <= '0;
            md_in_1_reg     <= '0;
            md_in_2_reg     <= '0;
        end else if (accept) begin
            op_reg          <= vec.req_op;
            out_sel_reg     <= vec.req_out_sel;
            in_1_signed_reg <= vec.req_in_1_signed;
            in_2_signed_reg <= vec.req_in_2_signed;
            in_1_reg        <= vec.req_in_1;
            in_2_reg        <= vec.req_in_2;
            md_in_1_reg     <= vec.req_in_1[XPR_LEN-1:0];
            md_in_2_reg     <= vec.req_in_2[XPR_LEN-1:0];
        end else if (lane_adv) begin
            md_in_1_reg     <= in_1_lane[lane_inc];
            md_in_2_reg     <= in_2_lane[lane_inc];
        end
    end

    // Result gather: each returning scalar result lands in its lane slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                res_lane_reg[i] <= '0;
            end
        end else if (lane_wr) begin
            res_lane_reg[lane_reg] <= md.resp_result;
        end
    end

    // Pack the lane results into the vector result bus.
    always_comb begin
        result_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            result_vec[i*XPR_LEN +: XPR_LEN] = res_lane_reg[i];
        end
    end

    assign vec.req_ready       = req_ready_c;
    assign vec.resp_valid      = resp_valid_c;
    assign vec.resp_result     = result_vec;

    assign md.req_valid        = md_req_valid_c;
    assign md.req_op           = op_reg;
    assign md.req_out_sel      = out_sel_reg;
    assign md.req_in_1_signed  = in_1_signed_reg;
    assign md.req_in_2_signed  = in_2_signed_reg;
    assign md.req_in_1         = md_in_1_reg;
    assign md.req_in_2         = md_in_2_reg;

endmodule

// File: tb/tb_xvec2_md_sequencer.sv
// Bench for xvec2_md_sequencer: behavioural scalar mul/div responder with a
// fixed latency, a table of vector operations with hand-computed results,
// and hand sequences for backpressure and kill corner cases.
module tb_xvec2_md_sequencer;

    localparam int XPR_LEN    = 32;
    localparam int LANES      = 4;
    localparam int VEC_W      = LANES * XPR_LEN;
    localparam int D          = 3;
    localparam int LAT        = LANES * (1 + D) + 1;
    localparam int STALL_LANE = 2;
    localparam int NVEC       = 5;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] SEL_LO = 2'd0;
    localparam logic [1:0] SEL_HI = 2'd1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic kill  = 1'b0;

    xvec2_md_sequencer_if #(.WIDTH(VEC_W))   vec_bus ();
    xvec2_md_sequencer_if #(.WIDTH(XPR_LEN)) md_bus ();

    xvec2_md_sequencer #(
        .XPR_LEN (XPR_LEN),
        .LANES   (LANES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kill  (kill),
        .vec   (vec_bus),
        .md    (md_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [1:0]   sel;
        logic         s1;
        logic         s2;
        logic [127:0] in_1;
        logic [127:0] in_2;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] exp;
        int           acc;
        int           lat;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } lane_t;

    vec_t  tbl [NVEC];
    sb_t   sb_q [$];
    lane_t lane_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Scalar mul/div responder state.
    logic        busy;
    int          cnt;
    int          hs_count;
    int          stall_done;
    int          stall_total = 0;
    logic [31:0] pend;

    function automatic logic [31:0] md_model(input logic [1:0] op, input logic [1:0] sel,
                                             input logic s1, input logic s2,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        if (op == OP_MUL) begin
            ea = s1 ? {{32{a[31]}}, a} : {32'b0, a};
            eb = s2 ? {{32{b[31]}}, b} : {32'b0, b};
            p  = ea * eb;
            return (sel == SEL_HI) ? p[63:32] : p[31:0];
        end
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (s1 && s2) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    assign md_bus.req_ready = !busy && !(hs_count == STALL_LANE && stall_done < stall_total);

    // Responder: result appears D cycles after the handshake cycle.
    always @(posedge clk) begin
        if (reset) begin
            busy               <= 1'b0;
            cnt                <= 0;
            hs_count           <= 0;
            stall_done         <= 0;
            md_bus.resp_valid  <= 1'b0;
            md_bus.resp_result <= '0;
        end else begin
            md_bus.resp_valid <= 1'b0;
            if (vec_bus.req_valid && vec_bus.req_ready) begin
                hs_count   <= 0;
                stall_done <= 0;
            end
            if (busy) begin
                if (cnt == 1) begin
                    busy               <= 1'b0;
                    md_bus.resp_valid  <= 1'b1;
                    md_bus.resp_result <= pend;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (md_bus.req_valid && md_bus.req_ready) begin
                busy     <= 1'b1;
                cnt      <= D - 1;
                pend     <= md_model(md_bus.req_op, md_bus.req_out_sel, md_bus.req_in_1_signed,
                                     md_bus.req_in_2_signed, md_bus.req_in_1, md_bus.req_in_2);
                hs_count <= hs_count + 1;
            end else if (md_bus.req_valid && !busy) begin
                stall_done <= stall_done + 1;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    // Advance to the next falling edge and run the per-cycle monitors.
    task automatic tick();
        sb_t   e;
        lane_t l;
        @(negedge clk);
        cyc++;
        if (vec_bus.resp_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_resp: got resp_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("resp_result", vec_bus.resp_result, e.exp);
                check("resp_latency", 128'(cyc - e.acc), 128'(e.lat));
            end
        end
        if (md_bus.req_valid) begin
            check("md_single_outstanding", 128'(busy), 128'(0));
        end
        if (md_bus.req_valid && md_bus.req_ready) begin
            if (lane_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_md_req: got md handshake, expected none (cycle %0d)", cyc);
            end else begin
                l = lane_q.pop_front();
                check("md_req_in_1", 128'(md_bus.req_in_1), 128'(l.a));
                check("md_req_in_2", 128'(md_bus.req_in_2), 128'(l.b));
            end
        end else if (md_bus.req_valid && !busy && lane_q.size() != 0) begin
            check("stall_hold_in_1", 128'(md_bus.req_in_1), 128'(lane_q[0].a));
        end
    endtask

    // Present a vector request, wait for accept, then scramble the inputs.
    task automatic send(input vec_t v, input int n_lanes, input bit want_resp, input int lat);
        lane_t l;
        sb_t   e;
        bit    got;
        for (int k = 0; k < n_lanes; k++) begin
            l.a = v.in_1[k*32 +: 32];
            l.b = v.in_2[k*32 +: 32];
            lane_q.push_back(l);
        end
        vec_bus.req_valid       = 1'b1;
        vec_bus.req_op          = v.op;
        vec_bus.req_out_sel     = v.sel;
        vec_bus.req_in_1_signed = v.s1;
        vec_bus.req_in_2_signed = v.s2;
        vec_bus.req_in_1        = v.in_1;
        vec_bus.req_in_2        = v.in_2;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (vec_bus.req_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) fail_now("accept_timeout");
        if (want_resp) begin
            e.exp = v.exp;
            e.acc = cyc;
            e.lat = lat;
            sb_q.push_back(e);
        end
        tick();
        vec_bus.req_valid       = 1'b0;
        vec_bus.req_in_1        = '1;
        vec_bus.req_in_2        = {$urandom, $urandom, $urandom, $urandom};
        vec_bus.req_op          = ~v.op;
        vec_bus.req_out_sel     = ~v.sel;
        vec_bus.req_in_1_signed = ~v.s1;
        vec_bus.req_in_2_signed = ~v.s2;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        if (sb_q.size() != 0) begin
            fail_now("resp_timeout");
            sb_q.delete();
        end
    endtask

    initial begin
        bit got;

        tbl[0] = '{name: "mul_lo_s", op: OP_MUL, sel: SEL_LO, s1: 1'b1, s2: 1'b1,
                   in_1: {32'd4, 32'd3, 32'd2, 32'hFFFF_FFFF},
                   in_2: {32'd5, 32'd6, 32'd7, 32'd8},
                   exp:  {32'd20, 32'd18, 32'd14, 32'hFFFF_FFF8}};
        tbl[1] = '{name: "mul_hi_u", op: OP_MUL, sel: SEL_HI, s1: 1'b0, s2: 1'b0,
                   in_1: {32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'd2},
                   in_2: {32'hFFFF_FFFF, 32'd2, 32'h0001_0000, 32'd3},
                   exp:  {32'hFFFF_FFFE, 32'd1, 32'd1, 32'd0}};
        tbl[2] = '{name: "mul_hi_s", op: OP_MUL, sel: SEL_HI, s1: 1'b1, s2: 1'b1,
                   in_1: {32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FFFD},
                   in_2: {32'hFFFF_FFFF, 32'd2, 32'd7, 32'd4},
                   exp:  {32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF}};
        tbl[3] = '{name: "div_u", op: OP_DIV, sel: SEL_LO, s1: 1'b0, s2: 1'b0,
                   in_1: {32'd100, 32'd7, 32'hFFFF_FFFF, 32'd9},
                   in_2: {32'd10, 32'd2, 32'd1, 32'd0},
                   exp:  {32'd10, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF}};
        tbl[4] = '{name: "div_s", op: OP_DIV, sel: SEL_LO, s1: 1'b1, s2: 1'b1,
                   in_1: {32'hFFFF_FFEC, 32'd20, 32'hFFFF_FFF9, 32'd1},
                   in_2: {32'd4, 32'hFFFF_FFFC, 32'd2, 32'd0},
                   exp:  {32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFFF}};

        vec_bus.req_valid       = 1'b1;
        vec_bus.req_op          = '0;
        vec_bus.req_out_sel     = '0;
        vec_bus.req_in_1_signed = 1'b0;
        vec_bus.req_in_2_signed = 1'b0;
        vec_bus.req_in_1        = '0;
        vec_bus.req_in_2        = '0;

        // Reset held two cycles with a request pending.
        tick();
        check("rst_req_ready", 128'(vec_bus.req_ready), 128'(0));
        tick();
        check("rst_req_ready2", 128'(vec_bus.req_ready), 128'(0));
        check("rst_resp_valid", 128'(vec_bus.resp_valid), 128'(0));
        check("rst_md_req_valid", 128'(md_bus.req_valid), 128'(0));
        check("rst_resp_result", vec_bus.resp_result, 128'(0));
        reset             = 1'b0;
        vec_bus.req_valid = 1'b0;
        #1;
        check("rst_release_ready", 128'(vec_bus.req_ready), 128'(1));
        tick();

        // Table of vector operations, normal flow.
        for (int i = 0; i < NVEC; i++) begin
            send(tbl[i], LANES, 1'b1, LAT);
            wait_done();
        end

        // Backpressure: scalar unit stalls 5 cycles before taking lane 2.
        stall_total = 5;
        send(tbl[0], LANES, 1'b1, LAT + 5);
        wait_done();
        stall_total = 0;

        // Kill while waiting on lane 1: drain the orphaned scalar result.
        send(tbl[1], 2, 1'b0, 0);
        for (int k = 0; k < 100; k++) begin
            if (lane_q.size() == 0) break;
            tick();
        end
        tick();
        kill = 1'b1;
        #1;
        check("kill_wait_ready", 128'(vec_bus.req_ready), 128'(0));
        tick();
        kill = 1'b0;
        #1;
        check("drain_ready_low", 128'(vec_bus.req_ready), 128'(0));
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (md_bus.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("drain_resp_timeout");
        check("drain_ready_on_resp", 128'(vec_bus.req_ready), 128'(0));
        tick();
        check("drain_ready_back", 128'(vec_bus.req_ready), 128'(1));
        send(tbl[2], LANES, 1'b1, LAT);
        wait_done();

        // Kill during DONE: response suppressed, back to IDLE.
        send(tbl[3], LANES, 1'b0, 0);
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (lane_q.size() == 0 && md_bus.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("done_wait_timeout");
        @(posedge clk);
        #1;
        kill = 1'b1;
        #1;
        check("done_kill_resp_valid", 128'(vec_bus.resp_valid), 128'(0));
        check("done_kill_ready", 128'(vec_bus.req_ready), 128'(0));
        tick();
        @(posedge clk);
        #1;
        kill = 1'b0;
        #1;
        check("done_kill_idle", 128'(vec_bus.req_ready), 128'(1));
        check("done_kill_result_kept", vec_bus.resp_result, tbl[3].exp);

        // Kill in IDLE with a request pending: no accept, no scalar request.
        tick();
        kill                    = 1'b1;
        vec_bus.req_valid       = 1'b1;
        vec_bus.req_in_1        = tbl[4].in_1;
        vec_bus.req_in_2        = tbl[4].in_2;
        #1;
        check("idle_kill_ready", 128'(vec_bus.req_ready), 128'(0));
        tick();
        check("idle_kill_no_md1", 128'(md_bus.req_valid), 128'(0));
        tick();
        check("idle_kill_no_md2", 128'(md_bus.req_valid), 128'(0));
        kill              = 1'b0;
        vec_bus.req_valid = 1'b0;
        #1;
        check("idle_kill_no_accept", 128'(vec_bus.req_ready), 128'(1));

        send(tbl[4], LANES, 1'b1, LAT);
        wait_done();

        for (int k = 0; k < 4; k++) tick();
        check("sb_empty", 128'(sb_q.size()), 128'(0));
        check("lane_q_empty", 128'(lane_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
